// File: rtl/accel_pkg.sv
// Shared types and register map for the accelerator control block.
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    ABORT  = 2'd3
  } fsm_state_e;

  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h04;
  localparam logic [7:0] ADR_KEY0   = 8'h10;
  localparam logic [7:0] ADR_DIN0   = 8'h20;
  localparam logic [7:0] ADR_DOUT0  = 8'h30;
  localparam logic [7:0] ADR_CYCLES = 8'h40;
  localparam logic [7:0] ADR_ID     = 8'h44;

  localparam int CTRL_START  = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_ABORT  = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_TIMEOUT = 2;
  localparam int ST_ERR     = 3;

  localparam logic [31:0] ID_VALUE_DEF = 32'hACC0_0001;

endpackage

// File: rtl/accel_regfile.sv
// Register storage for the accelerator: CTRL/STATUS/KEY/DIN/DOUT/CYCLES/ID,
// sticky W1C status flags, busy write protection and a combinational read mux.
module accel_regfile
  import accel_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [7:0]       i_adr,
  input  logic [31:0]      i_wdata,
  input  logic             i_we,
  input  logic             i_re,
  output logic [31:0]      o_rdata,
  input  logic             i_busy,
  input  logic             i_done_evt,
  input  logic             i_to_evt,
  input  logic             i_cyc_we,
  input  logic [CNT_W-1:0] i_cyc_val,
  input  logic [127:0]     i_dout,
  output logic             o_start_req,
  output logic             o_abort_req,
  output logic             o_mode,
  output logic [127:0]     o_key,
  output logic [127:0]     o_din,
  output logic             o_irq
);

  localparam logic [5:0] W_CTRL   = ADR_CTRL[7:2];
  localparam logic [5:0] W_STATUS = ADR_STATUS[7:2];
  localparam logic [5:0] W_CYCLES = ADR_CYCLES[7:2];
  localparam logic [5:0] W_ID     = ADR_ID[7:2];
  localparam logic [3:0] R_KEY    = ADR_KEY0[7:4];
  localparam logic [3:0] R_DIN    = ADR_DIN0[7:4];
  localparam logic [3:0] R_DOUT   = ADR_DOUT0[7:4];

  logic [3:0][31:0] r_key;
  logic [3:0][31:0] r_din;
  logic [3:0][31:0] r_dout;
  logic [CNT_W-1:0] r_cycles;
  logic             r_mode;
  logic             r_irq_en;
  logic             r_done;
  logic             r_timeout;
  logic             r_err;
  logic             r_irq;

  logic [5:0] w_word;
  logic [1:0] w_idx;
  logic       w_wr_ctrl;
  logic       w_wr_status;
  logic       w_wr_key;
  logic       w_wr_din;
  logic       w_err_set;
  logic       w_irq_en_nx;
  logic       w_done_nx;
  logic       w_to_nx;
  logic       w_err_nx;
  logic       w_unused;

  assign w_word      = i_adr[7:2];
  assign w_idx       = i_adr[3:2];
  assign w_wr_ctrl   = i_we && (w_word == W_CTRL);
  assign w_wr_status = i_we && (w_word == W_STATUS);
  assign w_wr_key    = i_we && (i_adr[7:4] == R_KEY);
  assign w_wr_din    = i_we && (i_adr[7:4] == R_DIN);
  assign w_unused    = ^{i_re, i_adr[1:0]};

  // A CTRL write while busy is only an error if it tries to start or flip MODE.
  assign w_err_set = i_busy && (w_wr_key || w_wr_din ||
                     (w_wr_ctrl && (i_wdata[CTRL_START] || (i_wdata[CTRL_MODE] != r_mode))));

  assign o_start_req = w_wr_ctrl && i_wdata[CTRL_START] && !i_busy;
  assign o_abort_req = w_wr_ctrl && i_wdata[CTRL_ABORT];

  assign w_irq_en_nx = w_wr_ctrl ? i_wdata[CTRL_IRQ_EN] : r_irq_en;
  assign w_done_nx   = (r_done    && !(w_wr_status && i_wdata[ST_DONE]))    || i_done_evt;
  assign w_to_nx     = (r_timeout && !(w_wr_status && i_wdata[ST_TIMEOUT])) || i_to_evt;
  assign w_err_nx    = (r_err     && !(w_wr_status && i_wdata[ST_ERR]))     || w_err_set;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_key     <= '0;
      r_din     <= '0;
      r_dout    <= '0;
      r_cycles  <= '0;
      r_mode    <= 1'b0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_nx;
      if (w_wr_ctrl && !i_busy) r_mode <= i_wdata[CTRL_MODE];
      if (w_wr_key && !i_busy) r_key[w_idx] <= i_wdata;
      if (w_wr_din && !i_busy) r_din[w_idx] <= i_wdata;
      if (i_done_evt) r_dout <= i_dout;
      if (i_cyc_we) r_cycles <= i_cyc_val;
      r_done    <= w_done_nx;
      r_timeout <= w_to_nx;
      r_err     <= w_err_nx;
      r_irq     <= w_irq_en_nx && (w_done_nx || w_to_nx);
    end
  end

  always_comb begin
    o_rdata = '0;
    case (w_word)
      W_CTRL: begin
        o_rdata[CTRL_MODE]   = r_mode;
        o_rdata[CTRL_IRQ_EN] = r_irq_en;
      end
      W_STATUS: begin
        o_rdata[ST_BUSY]    = i_busy;
        o_rdata[ST_DONE]    = r_done;
        o_rdata[ST_TIMEOUT] = r_timeout;
        o_rdata[ST_ERR]     = r_err;
      end
      W_CYCLES: o_rdata[CNT_W-1:0] = r_cycles;
      W_ID:     o_rdata = ID_VALUE;
      default: begin
        case (i_adr[7:4])
          R_KEY:   o_rdata = r_key[w_idx];
          R_DIN:   o_rdata = r_din[w_idx];
          R_DOUT:  o_rdata = r_dout[w_idx];
          default: o_rdata = '0;
        endcase
      end
    endcase
  end

  assign o_mode = r_mode;
  assign o_key  = r_key;
  assign o_din  = r_din;
  assign o_irq  = r_irq;

endmodule

// File: rtl/accel_ctrl.sv
// Accelerator operation sequencer: launches one block op, supervises it with a
// timeout counter and feeds completion/abort events into the register bank.
module accel_ctrl
  import accel_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          CNT_W          = 16,
  parameter logic [31:0] ID_VALUE       = ID_VALUE_DEF
) (
  input  logic         clk,
  input  logic         rst_ni,
  input  logic [7:0]   reg_adr_i,
  input  logic [31:0]  reg_wdata_i,
  input  logic         reg_we_i,
  input  logic         reg_re_i,
  output logic [31:0]  reg_rdata_o,
  output logic         core_start_o,
  output logic         core_abort_o,
  output logic         core_mode_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_din_o,
  input  logic [127:0] core_dout_i,
  input  logic         core_done_i,
  output logic         irq_o
);

  fsm_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start;
  logic             r_abort;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cyc_val;
  logic             w_busy;
  logic             w_run;
  logic             w_tc;
  logic             w_done_evt;
  logic             w_to_evt;
  logic             w_cyc_we;
  logic             w_start_req;
  logic             w_abort_req;

  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_busy     = (r_state != IDLE);
  assign w_run      = (r_state == RUN);
  assign w_tc       = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_done_evt = w_run && core_done_i;
  assign w_to_evt   = w_run && !core_done_i && w_tc;

  // CYCLES counts RUN cycles including the one in which the op ends.
  assign w_cyc_we  = w_done_evt || (r_state == ABORT);
  assign w_cyc_val = (r_state == ABORT) ? r_cnt : w_cnt_inc;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_req) begin
            r_state <= LAUNCH;
            r_start <= 1'b1;
          end
        end
        LAUNCH: begin
          r_cnt <= '0;
          if (w_abort_req) begin
            r_state <= ABORT;
            r_abort <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          r_cnt <= w_cnt_inc;
          if (core_done_i) begin
            r_state <= IDLE;
          end else if (w_tc || w_abort_req) begin
            r_state <= ABORT;
            r_abort <= 1'b1;
          end
        end
        ABORT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  accel_regfile #(
    .CNT_W    (CNT_W),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk         (clk),
    .rst_ni      (rst_ni),
    .i_adr       (reg_adr_i),
    .i_wdata     (reg_wdata_i),
    .i_we        (reg_we_i),
    .i_re        (reg_re_i),
    .o_rdata     (reg_rdata_o),
    .i_busy      (w_busy),
    .i_done_evt  (w_done_evt),
    .i_to_evt    (w_to_evt),
    .i_cyc_we    (w_cyc_we),
    .i_cyc_val   (w_cyc_val),
    .i_dout      (core_dout_i),
    .o_start_req (w_start_req),
    .o_abort_req (w_abort_req),
    .o_mode      (core_mode_o),
    .o_key       (core_key_o),
    .o_din       (core_din_o),
    .o_irq       (irq_o)
  );

  assign core_start_o = r_start;
  assign core_abort_o = r_abort;

endmodule

// File: tb/tb_accel_ctrl.sv
// Directed bench for accel_ctrl: instance a uses the default timeout, instance b
// a 16-cycle timeout; both share the register bus but have separate write strobes.
module tb_accel_ctrl;

  logic         clk = 1'b0;
  logic         rst_ni = 1'b0;
  logic [7:0]   adr = '0;
  logic [31:0]  wdata = '0;
  logic         we_a = 1'b0, we_b = 1'b0, re = 1'b0;
  logic         done_a = 1'b0, done_b = 1'b0;
  logic [127:0] dout_a = '0, dout_b = '0;

  logic [31:0]  rdata_a, rdata_b;
  logic         start_a, abort_a, mode_a, irq_a;
  logic         start_b, abort_b, mode_b, irq_b;
  logic [127:0] key_a, din_a, key_b, din_b;

  int total = 0;
  int bad = 0;
  int n_start_a = 0;
  int n_abort_a = 0;

  localparam logic [127:0] KEY_EXP = 128'hCCDDEEFF_8899AABB_44556677_00112233;
  localparam logic [127:0] DIN_EXP = 128'hA5A55A5A_01020304_CAFEF00D_DEADBEEF;
  localparam logic [127:0] RES1    = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] RES2    = 128'hFFEEDDCC_BBAA9988_77665544_33221100;

  accel_ctrl u_dut_a (
    .clk(clk), .rst_ni(rst_ni), .reg_adr_i(adr), .reg_wdata_i(wdata),
    .reg_we_i(we_a), .reg_re_i(re), .reg_rdata_o(rdata_a),
    .core_start_o(start_a), .core_abort_o(abort_a), .core_mode_o(mode_a),
    .core_key_o(key_a), .core_din_o(din_a), .core_dout_i(dout_a),
    .core_done_i(done_a), .irq_o(irq_a)
  );

  accel_ctrl #(.TIMEOUT_CYCLES(16)) u_dut_b (
    .clk(clk), .rst_ni(rst_ni), .reg_adr_i(adr), .reg_wdata_i(wdata),
    .reg_we_i(we_b), .reg_re_i(re), .reg_rdata_o(rdata_b),
    .core_start_o(start_b), .core_abort_o(abort_b), .core_mode_o(mode_b),
    .core_key_o(key_b), .core_din_o(din_b), .core_dout_i(dout_b),
    .core_done_i(done_b), .irq_o(irq_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_a) n_start_a++;
    if (abort_a) n_abort_a++;
  end

  typedef struct {
    bit          wr;
    logic [7:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input bit sel_b, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    adr = a;
    wdata = d;
    if (sel_b) we_b = 1'b1;
    else       we_a = 1'b1;
    @(negedge clk);
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic rd(input bit sel_b, input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    adr = a;
    re = 1'b1;
    #1;
    d = sel_b ? rdata_b : rdata_a;
    re = 1'b0;
  endtask

  initial begin
    logic [31:0]  r;
    logic [127:0] exp_d;
    int s0, a0, first, npulse;

    vt[0]  = '{1'b0, 8'h00, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 8'h04, 32'h0,        32'h0};
    vt[2]  = '{1'b0, 8'h40, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 8'h44, 32'h0,        32'hACC00001};
    vt[4]  = '{1'b1, 8'h10, 32'h00112233, 32'h00112233};
    vt[5]  = '{1'b1, 8'h14, 32'h44556677, 32'h44556677};
    vt[6]  = '{1'b1, 8'h18, 32'h8899AABB, 32'h8899AABB};
    vt[7]  = '{1'b1, 8'h1C, 32'hCCDDEEFF, 32'hCCDDEEFF};
    vt[8]  = '{1'b1, 8'h20, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[9]  = '{1'b1, 8'h24, 32'hCAFEF00D, 32'hCAFEF00D};
    vt[10] = '{1'b1, 8'h28, 32'h01020304, 32'h01020304};
    vt[11] = '{1'b1, 8'h2C, 32'hA5A55A5A, 32'hA5A55A5A};
    vt[12] = '{1'b0, 8'h13, 32'h0,        32'h00112233};
    vt[13] = '{1'b1, 8'h30, 32'hFFFFFFFF, 32'h0};
    vt[14] = '{1'b1, 8'h50, 32'h12345678, 32'h0};
    vt[15] = '{1'b1, 8'h00, 32'h00000006, 32'h00000006};
    vt[16] = '{1'b1, 8'h04, 32'h0000000F, 32'h0};
    vt[17] = '{1'b1, 8'h44, 32'h0,        32'hACC00001};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {start_a, abort_a, irq_a, mode_a, start_b, abort_b}, 0);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) wr(1'b0, vt[i].adr, vt[i].wd);
      rd(1'b0, vt[i].adr, r);
      chk($sformatf("vec%0d_adr%02h", i, vt[i].adr), r, vt[i].exp);
    end
    chk("key_out", key_a, KEY_EXP);
    chk("din_out", din_a, DIN_EXP);
    chk("mode_out", mode_a, 1);

    // basic op: done lands in the 20th RUN cycle
    s0 = n_start_a;
    wr(1'b0, 8'h00, 32'h5);
    chk("op_start_pulse", start_a, 1);
    chk("op_mode", mode_a, 0);
    repeat (20) @(negedge clk);
    dout_a = RES1;
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    dout_a = '0;
    chk("op_irq", irq_a, 1);
    rd(1'b0, 8'h04, r); chk("op_status", r, 32'h2);
    rd(1'b0, 8'h40, r); chk("op_cycles", r, 32'd20);
    exp_d = RES1;
    for (int k = 0; k < 4; k++) begin
      rd(1'b0, 8'h30 + 8'(4 * k), r);
      chk($sformatf("op_dout%0d", k), r, exp_d[32*k +: 32]);
    end
    chk("op_one_start", n_start_a - s0, 1);

    wr(1'b0, 8'h04, 32'h2);
    chk("clr_irq", irq_a, 0);
    rd(1'b0, 8'h04, r); chk("clr_status", r, 32'h0);

    // writes during RUN are blocked and flagged
    s0 = n_start_a;
    wr(1'b0, 8'h00, 32'h5);
    wr(1'b0, 8'h20, 32'hFFFFFFFF);
    wr(1'b0, 8'h00, 32'h5);
    chk("busy_din", din_a, DIN_EXP);
    rd(1'b0, 8'h04, r); chk("busy_status", r, 32'h9);
    chk("busy_no_restart", n_start_a - s0, 1);

    // done and ABORT write in the same cycle
    a0 = n_abort_a;
    @(negedge clk);
    adr = 8'h00; wdata = 32'hC; we_a = 1'b1; done_a = 1'b1; dout_a = RES2;
    @(negedge clk);
    we_a = 1'b0; done_a = 1'b0; dout_a = '0;
    chk("race_abort_low", abort_a, 0);
    rd(1'b0, 8'h04, r); chk("race_status", r, 32'hA);
    chk("race_no_abort", n_abort_a - a0, 0);
    chk("race_irq", irq_a, 1);
    rd(1'b0, 8'h3C, r); chk("race_dout3", r, 32'hFFEEDDCC);
    rd(1'b0, 8'h30, r); chk("race_dout0", r, 32'h33221100);

    wr(1'b0, 8'h04, 32'hE);
    rd(1'b0, 8'h04, r); chk("clr_all", r, 32'h0);

    // START+ABORT while idle launches only; ABORT write in RUN aborts without a flag
    a0 = n_abort_a;
    wr(1'b0, 8'h00, 32'h9);
    chk("sa_start", start_a, 1);
    rd(1'b0, 8'h04, r); chk("sa_busy", r, 32'h1);
    chk("sa_no_abort", n_abort_a - a0, 0);
    wr(1'b0, 8'h00, 32'h8);
    chk("abort_pulse", abort_a, 1);
    rd(1'b0, 8'h04, r); chk("abort_status", r, 32'h0);
    chk("abort_count", n_abort_a - a0, 1);

    @(negedge clk);
    done_a = 1'b1; dout_a = '1;
    @(negedge clk);
    done_a = 1'b0; dout_a = '0;
    rd(1'b0, 8'h04, r); chk("idle_done_status", r, 32'h0);
    rd(1'b0, 8'h3C, r); chk("idle_done_dout3", r, 32'hFFEEDDCC);

    // timeout on instance b (16 cycles)
    wr(1'b1, 8'h00, 32'h3);
    chk("to_start", start_b, 1);
    chk("to_mode", mode_b, 1);
    first = -1;
    npulse = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (abort_b) begin
        npulse++;
        if (first < 0) first = i;
      end
    end
    chk("to_latency", first, 17);
    chk("to_width", npulse, 1);
    rd(1'b1, 8'h04, r); chk("to_status", r, 32'h4);
    rd(1'b1, 8'h40, r); chk("to_cycles", r, 32'd16);
    chk("to_irq_off", irq_b, 0);

    // asynchronous reset in the middle of an op
    wr(1'b0, 8'h00, 32'h7);
    repeat (3) @(negedge clk);
    chk("pre_rst_mode", mode_a, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_ctl", {start_a, abort_a, irq_a, mode_a}, 0);
    chk("rst_key", key_a, 0);
    chk("rst_din", din_a, 0);
    rd(1'b0, 8'h04, r); chk("rst_status", r, 32'h0);
    rd(1'b0, 8'h44, r); chk("rst_id", r, 32'hACC00001);
    rd(1'b0, 8'h00, r); chk("rst_ctrl", r, 32'h0);
    rd(1'b0, 8'h40, r); chk("rst_cycles", r, 32'h0);
    rst_ni = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
